// File: rtl/wbu_pkg.sv
// Writeback-unit types and helpers shared by the WBU and its register slices.
`include "defines.v"

package wbu_pkg;

    localparam int unsigned XLEN = `CPU_WIDTH;
    localparam int unsigned NREG = `REG_NUM;
    localparam int unsigned RD_W = 5;
    localparam int unsigned AW   = $clog2(NREG);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_beat_t;

    // A destination is live only if it is non-zero and exists in RV32E.
    function automatic logic rd_live(input logic [RD_W-1:0] rd);
        return (32'(rd) < NREG) && (rd != '0);
    endfunction

    function automatic logic [AW-1:0] rd_addr(input logic [RD_W-1:0] rd);
        return rd[AW-1:0];
    endfunction

endpackage

// File: rtl/defines.v
// Shared core-wide width defines.
`ifndef CORE_DEFINES_V
`define CORE_DEFINES_V
`define CPU_WIDTH 32
`define REG_NUM 16
`endif

// File: rtl/wbu_reg.sv
// Enabled register slice with asynchronous active-low clear.
module wbu_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wbu.sv
// Writeback unit: arbitrates ALU/load results into one RF write port and tracks pending writes.
module wbu
    import wbu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [RD_W-1:0] exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RD_W-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_valid,
    input  logic [RD_W-1:0] iss_rd,
    output logic            iss_stall,
    output logic            rf_wen,
    output logic [RD_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy,
    output logic [XLEN-1:0] s_commit_cnt
);

    logic            lsu_fire;
    logic            exu_fire;
    logic            beat_live;
    logic            iss_fire;
    logic [RD_W-1:0] beat_rd;
    wb_beat_t        beat_d;
    wb_beat_t        beat_q;
    logic            wen_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic [XLEN-1:0] cnt_q;
    logic [XLEN-1:0] cnt_d;

    // Loads have fixed priority; both channels are closed while in reset.
    assign lsu_ready = rst;
    assign exu_ready = rst && !lsu_valid;

    always_comb begin
        lsu_fire    = lsu_valid && lsu_ready;
        exu_fire    = exu_valid && exu_ready;
        beat_rd     = lsu_fire ? lsu_rd : exu_rd;
        beat_d.addr = rd_addr(beat_rd);
        beat_d.data = lsu_fire ? lsu_data : exu_data;
        beat_live   = (lsu_fire || exu_fire) && rd_live(beat_rd);

        iss_stall   = iss_valid && rd_live(iss_rd) && busy_q[rd_addr(iss_rd)];
        iss_fire    = iss_valid && rd_live(iss_rd) && !iss_stall;

        // A new reservation wins over a commit to the same register.
        busy_set    = iss_fire ? (NREG'(1) << rd_addr(iss_rd)) : '0;
        busy_clr    = wen_q ? (NREG'(1) << beat_q.addr) : '0;
        busy_d      = ((busy_q & ~busy_clr) | busy_set) & ~NREG'(1);

        cnt_d       = cnt_q + XLEN'(1);
    end

    wbu_reg #(.W(1)) u_wen_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (beat_live),
        .q   (wen_q)
    );

    // Address/data only move on a real commit so they hold between writes.
    wbu_reg #(.W($bits(wb_beat_t))) u_beat_reg (
        .clk (clk),
        .rst (rst),
        .en  (beat_live),
        .d   (beat_d),
        .q   (beat_q)
    );

    wbu_reg #(.W(NREG)) u_busy_reg (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (busy_d),
        .q   (busy_q)
    );

    wbu_reg #(.W(XLEN)) u_cnt_reg (
        .clk (clk),
        .rst (rst),
        .en  (beat_live),
        .d   (cnt_d),
        .q   (cnt_q)
    );

    assign rf_wen       = wen_q;
    assign rf_waddr     = RD_W'(beat_q.addr);
    assign rf_wdata     = beat_q.data;
    assign busy         = busy_q;
    assign s_commit_cnt = cnt_q;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: cycle table plus a mid-beat reset sequence.
module tb_wbu;
    import wbu_pkg::*;

    logic            clk;
    logic            rst;
    logic            exu_valid;
    logic            exu_ready;
    logic [RD_W-1:0] exu_rd;
    logic [XLEN-1:0] exu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [RD_W-1:0] lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            iss_valid;
    logic [RD_W-1:0] iss_rd;
    logic            iss_stall;
    logic            rf_wen;
    logic [RD_W-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] busy;
    logic [XLEN-1:0] s_commit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    wbu dut (
        .clk          (clk),
        .rst          (rst),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_rd       (exu_rd),
        .exu_data     (exu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_stall    (iss_stall),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
        .s_commit_cnt (s_commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [4:0]  er;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ir;
        logic        x_exu_ready;
        logic        x_stall;
        logic        x_wen;
        logic [4:0]  x_waddr;
        logic [31:0] x_wdata;
        logic [15:0] x_busy;
        logic [31:0] x_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        // ev er ed | lv lr ld | iv ir || exu_ready stall | wen waddr wdata busy cnt
        vq.push_back('{1, 5'd5,  32'h1234,  0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 1, 5'd5, 32'h1234, 16'h0000, 32'd1}); // 0
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 0, 5'd5, 32'h1234, 16'h0000, 32'd1}); // 1
        vq.push_back('{1, 5'd3,  32'hA,     1, 5'd4,  32'hB,    0, 5'd0,  0, 0, 1, 5'd4, 32'hB,    16'h0000, 32'd2}); // 2
        vq.push_back('{1, 5'd3,  32'hA,     0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 1, 5'd3, 32'hA,    16'h0000, 32'd3}); // 3
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    1, 5'd7,  1, 0, 0, 5'd3, 32'hA,    16'h0080, 32'd3}); // 4
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    1, 5'd7,  1, 1, 0, 5'd3, 32'hA,    16'h0080, 32'd3}); // 5
        vq.push_back('{0, 5'd0,  32'h0,     1, 5'd7,  32'h77,   0, 5'd0,  0, 0, 1, 5'd7, 32'h77,   16'h0080, 32'd4}); // 6
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 0, 5'd7, 32'h77,   16'h0000, 32'd4}); // 7
        vq.push_back('{1, 5'd9,  32'h99,    0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 1, 5'd9, 32'h99,   16'h0000, 32'd5}); // 8
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    1, 5'd9,  1, 0, 0, 5'd9, 32'h99,   16'h0200, 32'd5}); // 9
        vq.push_back('{1, 5'd0,  32'hFFFF,  0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 0, 5'd9, 32'h99,   16'h0200, 32'd5}); // 10
        vq.push_back('{0, 5'd0,  32'h0,     1, 5'h10, 32'hDEAD, 1, 5'd0,  0, 0, 0, 5'd9, 32'h99,   16'h0200, 32'd5}); // 11
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    1, 5'h19, 1, 0, 0, 5'd9, 32'h99,   16'h0200, 32'd5}); // 12
        vq.push_back('{1, 5'h1F, 32'hBAD,   0, 5'd0,  32'h0,    0, 5'd0,  1, 0, 0, 5'd9, 32'h99,   16'h0200, 32'd5}); // 13
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    1, 5'd9,  1, 1, 0, 5'd9, 32'h99,   16'h0200, 32'd5}); // 14
        vq.push_back('{1, 5'd3,  32'h33,    0, 5'd0,  32'h0,    1, 5'd3,  1, 0, 1, 5'd3, 32'h33,   16'h0208, 32'd6}); // 15
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    1, 5'd4,  1, 0, 0, 5'd3, 32'h33,   16'h0210, 32'd6}); // 16
        vq.push_back('{0, 5'd0,  32'h0,     1, 5'd9,  32'h9,    1, 5'd5,  0, 0, 1, 5'd9, 32'h9,    16'h0230, 32'd7}); // 17
        vq.push_back('{0, 5'd0,  32'h0,     0, 5'd0,  32'h0,    1, 5'd6,  1, 0, 0, 5'd9, 32'h9,    16'h0070, 32'd7}); // 18
        vq.push_back('{1, 5'd2,  32'h22,    0, 5'd0,  32'h0,    1, 5'd7,  1, 0, 1, 5'd2, 32'h22,   16'h00F0, 32'd8}); // 19

        drive_idle();
        rst = 1'b0;
        lsu_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lsu_ready", -1, 32'(lsu_ready), 32'd0);
        chk("reset_exu_ready", -1, 32'(exu_ready), 32'd0);
        chk("reset_rf_wen",    -1, 32'(rf_wen), 32'd0);
        chk("reset_rf_waddr",  -1, 32'(rf_waddr), 32'd0);
        chk("reset_rf_wdata",  -1, rf_wdata, 32'd0);
        chk("reset_busy",      -1, 32'(busy), 32'd0);
        chk("reset_cnt",       -1, s_commit_cnt, 32'd0);

        @(negedge clk);
        drive_idle();
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            exu_valid = vq[i].ev; exu_rd = vq[i].er; exu_data = vq[i].ed;
            lsu_valid = vq[i].lv; lsu_rd = vq[i].lr; lsu_data = vq[i].ld;
            iss_valid = vq[i].iv; iss_rd = vq[i].ir;
            #1;
            chk("exu_ready", i, 32'(exu_ready), 32'(vq[i].x_exu_ready));
            chk("lsu_ready", i, 32'(lsu_ready), 32'd1);
            chk("iss_stall", i, 32'(iss_stall), 32'(vq[i].x_stall));
            @(posedge clk);
            #1;
            chk("rf_wen",   i, 32'(rf_wen), 32'(vq[i].x_wen));
            chk("rf_waddr", i, 32'(rf_waddr), 32'(vq[i].x_waddr));
            chk("rf_wdata", i, rf_wdata, vq[i].x_wdata);
            chk("busy",     i, 32'(busy), 32'(vq[i].x_busy));
            chk("cnt",      i, s_commit_cnt, vq[i].x_cnt);
        end

        // Reset lands while the rd=2 beat sits in the write stage and busy=0x00F0.
        drive_idle();
        rst = 1'b0;
        #1;
        chk("midrst_rf_wen",    100, 32'(rf_wen), 32'd0);
        chk("midrst_busy",      100, 32'(busy), 32'd0);
        chk("midrst_rf_waddr",  100, 32'(rf_waddr), 32'd0);
        chk("midrst_rf_wdata",  100, rf_wdata, 32'd0);
        chk("midrst_cnt",       100, s_commit_cnt, 32'd0);
        chk("midrst_exu_ready", 100, 32'(exu_ready), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        exu_valid = 1'b1; exu_rd = 5'd2; exu_data = 32'h2222;
        #1;
        chk("post_exu_ready", 101, 32'(exu_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post_rf_wen",   101, 32'(rf_wen), 32'd1);
        chk("post_rf_waddr", 101, 32'(rf_waddr), 32'd2);
        chk("post_rf_wdata", 101, rf_wdata, 32'h2222);
        chk("post_cnt",      101, s_commit_cnt, 32'd1);
        chk("post_busy",     101, 32'(busy), 32'd0);

        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        chk("post_idle_wen", 102, 32'(rf_wen), 32'd0);
        chk("post_idle_cnt", 102, s_commit_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
